score_ram: RTL and testbench
============================

# score_ram

Eight-entry by 8-bit score store sitting directly downstream of the score RAM controller. It accepts the controller's `write_enable` / `address_set` / `data_out` strobes and returns registered read data on `score_check`, which the controller compares against the current score. It also:
- clears itself with a hardware sweep after reset or on request;
- provides a second registered read port for the high-score display.

## Interface
Parameters:
- `DEPTH`, 8: number of entries; address width is 3 bits.
- `WIDTH`, 8: score width in bits.
- `HI_ADDR`, 6: address reserved for the all-time high score.

Ports:
- `clk`, input, 1: single system clock; rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `clear_req`, input, 1: one-cycle pulse; starts a clear sweep of all entries.
- `write_enable`, input, 1: write strobe from the controller.
- `address_set`, input, 3: read/write address for port A.
- `data_in`, input, 8: write data; the controller's `data_out` connects here.
- `score_check`, output, 8: port A registered read data; feeds the controller.
- `disp_addr`, input, 3: port B read address for the display scanner.
- `disp_data`, output, 8: port B registered read data.
- `busy`, output, 1: high while a clear sweep is in progress.
- `max_seen`, output, 8: largest value ever written to addresses 0..5 since the last clear.

## Operation
- **States:**
  - `SWEEP`: entered on reset and from `IDLE` on `clear_req`.
  - `IDLE`: normal operation.
- **SWEEP:**
  - Internal pointer `clr_ptr` runs from 0 to 7.
  - Each cycle, `mem[clr_ptr]` is written to 0 and the pointer increments.
  - After writing entry 7, the pointer wraps to 0 and the FSM goes to `IDLE`.
  - The sweep lasts exactly 8 cycles. `busy` is high for all 8.
- **Writes and reads during SWEEP:**
  - `write_enable` is ignored; the data is dropped, not queued.
  - `score_check` and `disp_data` register 0.
  - `clear_req` is ignored; the sweep does not restart.
- **IDLE, port A:**
  - With `write_enable` = 1: `mem[address_set] <= data_in`.
  - Every cycle: `score_check <= mem[address_set]`.
- **IDLE, port B:** every cycle, `disp_data <= mem[disp_addr]`. Port B is read-only.
- **max_seen:**
  - On an IDLE write to an address 0..5 with `data_in` > `max_seen`, `max_seen <= data_in`.
  - Writes to address 6 or 7 never change it.
  - Cleared to 0 on the first cycle of any sweep.
- **Arithmetic:** all comparisons are unsigned 8-bit. No saturation is needed; values are stored verbatim.
- **Simultaneous events:**
  - `clear_req` together with `write_enable` in IDLE: the write is performed, then the sweep starts on the next cycle and erases it.
  - Port B reading the same address that port A is writing: port B returns the old value (no forwarding on port B in either build).
- **Reset mid-sweep:** restarts the sweep from entry 0 with `busy` = 1.

## Timing
- **Reset values (asynchronous):**
  - `score_check` = 0, `disp_data` = 0, `max_seen` = 0.
  - `busy` = 1; FSM = `SWEEP`; `clr_ptr` = 0.
  - Memory contents are not reset asynchronously; the sweep clears them.
- **After rst deasserts:** `busy` falls after the 8th rising edge. The first write is accepted on the 9th edge.
- **Read latency:**
  - 1 cycle: the address presented before edge N gives data on `score_check` / `disp_data` after edge N.
  - The controller's two wait states therefore cover the latency with one cycle of margin.
- **Write:** takes effect at the edge where `write_enable` is sampled high. A port A read of that address on the next edge returns the new data.
- **Same-edge read of the address being written:** see Configuration.

## Configuration
- **`SCORE_RAM_BYPASS_EN` defined:**
  - When `write_enable` is high in IDLE, port A forwards the write.
  - `score_check` registers `data_in` instead of the old `mem[address_set]`, giving write-through.
- **Not defined:** `score_check` registers the old contents (read-before-write).

## Structure
- Shared package `score_pkg`:
  - `WIDTH`, `DEPTH`, `HI_ADDR`.
  - `USER_ADDR_MAX` = 5.
  - The FSM state enum `{SWEEP, IDLE}`, shared with the controller's address constants.
- One sub-module, `score_ram_clear_seq`:
  - Owns the FSM, `clr_ptr` and `busy`.
  - Outputs a clear strobe and the clear address to the storage array in the top level.

## Test plan
- **Reset sweep:** assert and release `rst`, then hold `write_enable` = 1 at address 2 with data 0x55 during the sweep.
  - `busy` is high for exactly 8 cycles.
  - The write is dropped: reading address 2 afterwards returns 0x00.
- **Basic write/read:** write 0x08 to address 1; read address 1 on the next cycle.
  - `score_check` = 0x08 one cycle after the address is presented.
  - `max_seen` = 0x08.
- **High-score slot:** write 0x30 to address 6 (`HI_ADDR`).
  - Port B with `disp_addr` = 6 returns 0x30.
  - `max_seen` is unchanged.
- **Same-edge read/write:** write 0x21 to address 3 while reading address 3; address 3 previously held 0x10.
  - Without the macro: `score_check` = 0x10.
  - With `SCORE_RAM_BYPASS_EN`: `score_check` = 0x21.
- **clear_req with write:** in IDLE, pulse `clear_req` together with a write of 0x7F to address 0.
  - The write happens, then `busy` is high for 8 cycles.
  - Afterwards address 0 reads 0x00 and `max_seen` = 0.
- **Reset mid-sweep:** assert `rst` at sweep cycle 4.
  - `busy` stays high.
  - The sweep restarts and runs a full 8 cycles after the release.

Source files
------------

// File: rtl/score_pkg.sv
// score_pkg: shared constants and FSM state type for the score RAM and its controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package score_pkg;

  localparam int WIDTH         = 8;
  localparam int DEPTH         = 8;
  localparam int HI_ADDR       = 6;
  localparam int USER_ADDR_MAX = 5;
  localparam int ADDR_W        = 3;

  typedef enum logic {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } state_t;

endpackage

// File: rtl/score_ram_clear_seq.sv
// score_ram_clear_seq: sweep FSM that zeroes every entry after reset or on clear_req.
// Latency: sweep lasts exactly DEPTH cycles; busy is registered.
// Backpressure: none; clear_req is ignored while a sweep is running.
module score_ram_clear_seq
  import score_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  output logic              busy,
  output logic              clr_stb,
  output logic [ADDR_W-1:0] clr_addr
);

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;

  // Sweep FSM: walk clr_ptr over all entries, then idle until the next clear request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= SWEEP;
      clr_ptr <= '0;
      busy    <= 1'b1;
    end else begin
      case (state)
        SWEEP: begin
          // Pointer wraps naturally to 0 after the last entry.
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        IDLE: begin
          if (clear_req) begin
            state <= SWEEP;
            busy  <= 1'b1;
          end
        end
        default: begin
          state   <= SWEEP;
          clr_ptr <= '0;
          busy    <= 1'b1;
        end
      endcase
    end
  end

  assign clr_stb  = (state == SWEEP);
  assign clr_addr = clr_ptr;

endmodule

// File: rtl/score_ram.sv
// score_ram: 8x8 score store with registered port A (read/write) and port B (display read).
// Latency: 1 cycle on both read ports; optional SCORE_RAM_BYPASS_EN gives port A write-through.
// Backpressure: none; writes during a clear sweep are dropped and reads return 0.
module score_ram #(
  parameter int DEPTH   = score_pkg::DEPTH,
  parameter int WIDTH   = score_pkg::WIDTH,
  parameter int HI_ADDR = score_pkg::HI_ADDR
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear_req,
  input  logic                        write_enable,
  input  logic [score_pkg::ADDR_W-1:0] address_set,
  input  logic [WIDTH-1:0]            data_in,
  output logic [WIDTH-1:0]            score_check,
  input  logic [score_pkg::ADDR_W-1:0] disp_addr,
  output logic [WIDTH-1:0]            disp_data,
  output logic                        busy,
  output logic [WIDTH-1:0]            max_seen
);
  import score_pkg::*;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic              clr_stb;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_en;
  logic              user_slot;

  score_ram_clear_seq u_clear_seq (
    .clk       (clk),
    .rst       (rst),
    .clear_req (clear_req),
    .busy      (busy),
    .clr_stb   (clr_stb),
    .clr_addr  (clr_addr)
  );

  // Writes are only honoured outside a sweep; the high-score slot and above never feed max_seen.
  assign wr_en     = write_enable && !clr_stb;
  assign user_slot = (address_set <= ADDR_W'(USER_ADDR_MAX)) &&
                     (address_set != ADDR_W'(HI_ADDR));

  // Storage array: sweep zeroes one entry per cycle, otherwise port A writes.
  always_ff @(posedge clk) begin
    if (clr_stb) begin
      mem[clr_addr] <= '0;
    end else if (wr_en) begin
      mem[address_set] <= data_in;
    end
  end

  // Registered read ports; both return 0 while the sweep owns the array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_check <= '0;
      disp_data   <= '0;
    end else if (clr_stb) begin
      score_check <= '0;
      disp_data   <= '0;
    end else begin
`ifdef SCORE_RAM_BYPASS_EN
      score_check <= write_enable ? data_in : mem[address_set];
`else
      score_check <= mem[address_set];
`endif
      disp_data <= mem[disp_addr];
    end
  end

  // Running maximum of user-slot writes, cleared on the first cycle of every sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_seen <= '0;
    end else if (clr_stb && clr_addr == '0) begin
      max_seen <= '0;
    end else if (wr_en && user_slot && data_in > max_seen) begin
      max_seen <= data_in;
    end
  end

endmodule

// File: tb/tb_score_ram.sv
// tb_score_ram: randomized and directed checks of score_ram against a behavioural model.
// Latency: model expects 1-cycle reads and an 8-cycle sweep.
// Backpressure: model drops writes while busy.
module tb_score_ram;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear_req;
  logic       write_enable;
  logic [2:0] address_set;
  logic [7:0] data_in;
  logic [7:0] score_check;
  logic [2:0] disp_addr;
  logic [7:0] disp_data;
  logic       busy;
  logic [7:0] max_seen;

  int total = 0;
  int bad   = 0;

  // Reference model: plain array plus running maximum.
  logic [7:0] ref_mem [8];
  logic [7:0] ref_max;

  always #5 clk = ~clk;

  score_ram dut (
    .clk          (clk),
    .rst          (rst),
    .clear_req    (clear_req),
    .write_enable (write_enable),
    .address_set  (address_set),
    .data_in      (data_in),
    .score_check  (score_check),
    .disp_addr    (disp_addr),
    .disp_data    (disp_data),
    .busy         (busy),
    .max_seen     (max_seen)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;
    ref_max = 8'h00;
  endtask

  task automatic idle_inputs();
    clear_req    = 1'b0;
    write_enable = 1'b0;
    address_set  = 3'd0;
    data_in      = 8'h00;
    disp_addr    = 3'd0;
  endtask

  // Model of one IDLE write: store verbatim, track max over addresses 0..5.
  task automatic model_write(input logic [2:0] a, input logic [7:0] d);
    if (a <= 3'd5 && d > ref_max) ref_max = d;
    ref_mem[a] = d;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #3;
    total++; if (score_check !== 8'h00) begin bad++; $display("FAIL reset_score_check got=%h exp=00", score_check); end
    total++; if (disp_data !== 8'h00) begin bad++; $display("FAIL reset_disp_data got=%h exp=00", disp_data); end
    total++; if (max_seen !== 8'h00) begin bad++; $display("FAIL reset_max_seen got=%h exp=00", max_seen); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b exp=1", busy); end
    tick();
    rst = 1'b0;
    // Write attempt held for the whole sweep must be dropped.
    write_enable = 1'b1; address_set = 3'd2; data_in = 8'h55;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if (busy !== (i < 7)) begin bad++; $display("FAIL reset_sweep_busy cycle=%0d got=%b exp=%b", i, busy, (i < 7)); end
      if (i < 7) begin
        total++;
        if (score_check !== 8'h00) begin bad++; $display("FAIL sweep_read_zero cycle=%0d got=%h exp=00", i, score_check); end
      end
    end
    model_clear();
    idle_inputs();
    address_set = 3'd2;
    tick();
    total++; if (score_check !== 8'h00) begin bad++; $display("FAIL sweep_drop_write got=%h exp=00", score_check); end
    total++; if (max_seen !== 8'h00) begin bad++; $display("FAIL sweep_max_seen got=%h exp=00", max_seen); end
  endtask

  task automatic test_basic();
    write_enable = 1'b1; address_set = 3'd1; data_in = 8'h08;
    tick();
    model_write(3'd1, 8'h08);
    write_enable = 1'b0;
    tick();
    total++; if (score_check !== 8'h08) begin bad++; $display("FAIL basic_read got=%h exp=08", score_check); end
    total++; if (max_seen !== 8'h08) begin bad++; $display("FAIL basic_max got=%h exp=08", max_seen); end
  endtask

  task automatic test_hi_slot();
    write_enable = 1'b1; address_set = 3'd6; data_in = 8'h30;
    tick();
    model_write(3'd6, 8'h30);
    address_set = 3'd7; data_in = 8'hFF;
    tick();
    model_write(3'd7, 8'hFF);
    write_enable = 1'b0; disp_addr = 3'd6;
    tick();
    total++; if (disp_data !== 8'h30) begin bad++; $display("FAIL hi_slot_disp got=%h exp=30", disp_data); end
    total++; if (max_seen !== 8'h08) begin bad++; $display("FAIL hi_slot_max got=%h exp=08", max_seen); end
  endtask

  task automatic test_same_edge();
    logic [7:0] exp_sc;
    write_enable = 1'b1; address_set = 3'd3; data_in = 8'h10;
    tick();
    model_write(3'd3, 8'h10);
    data_in = 8'h21; disp_addr = 3'd3;
`ifdef SCORE_RAM_BYPASS_EN
    exp_sc = 8'h21;
`else
    exp_sc = 8'h10;
`endif
    tick();
    model_write(3'd3, 8'h21);
    total++; if (score_check !== exp_sc) begin bad++; $display("FAIL same_edge_porta got=%h exp=%h", score_check, exp_sc); end
    total++; if (disp_data !== 8'h10) begin bad++; $display("FAIL same_edge_portb got=%h exp=10", disp_data); end
    write_enable = 1'b0;
    tick();
    total++; if (score_check !== 8'h21) begin bad++; $display("FAIL same_edge_after got=%h exp=21", score_check); end
  endtask

  task automatic test_random();
    logic [7:0] exp_sc, exp_dd;
    for (int n = 0; n < 300; n++) begin
      write_enable = 1'($urandom_range(0, 1));
      address_set  = 3'($urandom_range(0, 7));
      data_in      = 8'($urandom);
      disp_addr    = 3'($urandom_range(0, 7));
      exp_sc = (write_enable) ? (
`ifdef SCORE_RAM_BYPASS_EN
                 data_in
`else
                 ref_mem[address_set]
`endif
               ) : ref_mem[address_set];
      exp_dd = ref_mem[disp_addr];
      if (write_enable) model_write(address_set, data_in);
      tick();
      total++; if (score_check !== exp_sc) begin bad++; $display("FAIL rand_score_check n=%0d got=%h exp=%h", n, score_check, exp_sc); end
      total++; if (disp_data !== exp_dd) begin bad++; $display("FAIL rand_disp_data n=%0d got=%h exp=%h", n, disp_data, exp_dd); end
      total++; if (max_seen !== ref_max) begin bad++; $display("FAIL rand_max_seen n=%0d got=%h exp=%h", n, max_seen, ref_max); end
    end
    idle_inputs();
  endtask

  task automatic test_clear_with_write();
    clear_req = 1'b1; write_enable = 1'b1; address_set = 3'd0; data_in = 8'h7F;
    tick();
    model_write(3'd0, 8'h7F);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL clear_busy_start got=%b exp=1", busy); end
    total++; if (max_seen !== ref_max) begin bad++; $display("FAIL clear_write_max got=%h exp=%h", max_seen, ref_max); end
    // Further clear requests and writes during the sweep are ignored.
    clear_req = 1'b1; write_enable = 1'b1; address_set = 3'd4; data_in = 8'hEE;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if (busy !== (i < 7)) begin bad++; $display("FAIL clear_sweep_busy cycle=%0d got=%b exp=%b", i, busy, (i < 7)); end
      if (i == 0) begin
        total++;
        if (max_seen !== 8'h00) begin bad++; $display("FAIL clear_max_first got=%h exp=00", max_seen); end
      end
      if (i == 6) clear_req = 1'b0;
      if (i == 6) write_enable = 1'b0;
    end
    model_clear();
    idle_inputs();
    address_set = 3'd0; disp_addr = 3'd4;
    tick();
    total++; if (score_check !== 8'h00) begin bad++; $display("FAIL clear_addr0 got=%h exp=00", score_check); end
    total++; if (disp_data !== 8'h00) begin bad++; $display("FAIL clear_drop_addr4 got=%h exp=00", disp_data); end
    total++; if (max_seen !== 8'h00) begin bad++; $display("FAIL clear_max_after got=%h exp=00", max_seen); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL clear_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid_sweep();
    write_enable = 1'b1; address_set = 3'd5; data_in = 8'h44;
    tick();
    model_write(3'd5, 8'h44);
    write_enable = 1'b0; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midsweep_busy_rst got=%b exp=1", busy); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if (busy !== (i < 7)) begin bad++; $display("FAIL midsweep_restart_busy cycle=%0d got=%b exp=%b", i, busy, (i < 7)); end
    end
    model_clear();
    address_set = 3'd5;
    tick();
    total++; if (score_check !== 8'h00) begin bad++; $display("FAIL midsweep_addr5 got=%h exp=00", score_check); end
    write_enable = 1'b1; address_set = 3'd2; data_in = 8'h9A;
    tick();
    model_write(3'd2, 8'h9A);
    write_enable = 1'b0;
    tick();
    total++; if (score_check !== 8'h9A) begin bad++; $display("FAIL midsweep_write_after got=%h exp=9a", score_check); end
    total++; if (max_seen !== ref_max) begin bad++; $display("FAIL midsweep_max got=%h exp=%h", max_seen, ref_max); end
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    model_clear();
    test_reset();
    test_basic();
    test_hi_slot();
    test_same_edge();
    test_random();
    test_clear_with_write();
    test_random();
    test_reset_mid_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
